// File: rtl/urv_fetch.sv
// uRV instruction fetch: PC, one outstanding imem request, output slot plus one-entry hold buffer.
// Optional misaligned-target trap: define URV_FETCH_MISALIGN_TRAP_EN.
module urv_fetch #(
  parameter logic [31:0] g_boot_vector = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  input  logic        f_stall_i,
  input  logic        x_bra_i,
  input  logic [31:0] x_bra_target_i,
  output logic        f_valid_o,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
  output logic        f_misaligned_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic        outst_q, outst_d;
  logic        out_valid_q, out_valid_d, out_mis_q, out_mis_d;
  logic [31:0] out_ir_q, out_ir_d, out_pc_q, out_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_ir_q, hold_ir_d, hold_pc_q, hold_pc_d;
  logic        halted_q, halted_d;
  logic [31:0] bra_tgt;
  logic        bra_mis, resp, out_free, issue;

`ifdef URV_FETCH_MISALIGN_TRAP_EN
  assign bra_tgt = x_bra_target_i;
  assign bra_mis = (x_bra_target_i[1:0] != 2'b00);
`else
  assign bra_tgt = x_bra_target_i & 32'hFFFF_FFFC;
  assign bra_mis = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    outst_d      = outst_q;
    out_valid_d  = out_valid_q;
    out_mis_d    = out_mis_q;
    out_ir_d     = out_ir_q;
    out_pc_d     = out_pc_q;
    hold_valid_d = hold_valid_q;
    hold_ir_d    = hold_ir_q;
    hold_pc_d    = hold_pc_q;
    halted_d     = halted_q;
    issue        = 1'b0;
    resp         = im_valid_i && outst_q;
    out_free     = !out_valid_q || !f_stall_i;

    if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end else if (x_bra_i) begin
      out_valid_d  = bra_mis;
      out_mis_d    = bra_mis;
      if (bra_mis) begin
        out_ir_d = NOP;
        out_pc_d = bra_tgt;
      end
      hold_valid_d = 1'b0;
      pc_d         = bra_tgt;
      halted_d     = bra_mis;
      if (!outst_q || im_valid_i) begin
        outst_d = 1'b0;
        state_d = ST_RUN;
      end else begin
        state_d = ST_FLUSH;
      end
    end else if (state_q == ST_FLUSH) begin
      if (out_valid_q && !f_stall_i) out_valid_d = 1'b0;
      if (im_valid_i) begin
        outst_d = 1'b0;
        state_d = ST_RUN;
        issue   = !halted_q;
      end
    end else begin
      if (out_free) begin
        if (hold_valid_q) begin
          out_valid_d  = 1'b1;
          out_mis_d    = 1'b0;
          out_ir_d     = hold_ir_q;
          out_pc_d     = hold_pc_q;
          hold_valid_d = 1'b0;
        end else if (resp) begin
          out_valid_d = 1'b1;
          out_mis_d   = 1'b0;
          out_ir_d    = im_data_i;
          out_pc_d    = req_pc_q;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      if (resp && (!out_free || hold_valid_q)) begin
        hold_valid_d = 1'b1;
        hold_ir_d    = im_data_i;
        hold_pc_d    = req_pc_q;
      end
      if (resp) outst_d = 1'b0;
      // Gate on next-cycle hold occupancy so the reply always has a free slot.
      issue = !halted_q && (!outst_q || im_valid_i) && !hold_valid_d;
    end

    if (issue) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
      outst_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_BOOT;
      pc_q         <= g_boot_vector;
      req_pc_q     <= '0;
      outst_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_mis_q    <= 1'b0;
      out_ir_q     <= NOP;
      out_pc_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_ir_q    <= '0;
      hold_pc_q    <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      outst_q      <= outst_d;
      out_valid_q  <= out_valid_d;
      out_mis_q    <= out_mis_d;
      out_ir_q     <= out_ir_d;
      out_pc_q     <= out_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_ir_q    <= hold_ir_d;
      hold_pc_q    <= hold_pc_d;
      halted_q     <= halted_d;
    end
  end

  assign im_rd_o        = issue;
  assign im_addr_o      = {pc_q[31:2], 2'b00};
  assign f_valid_o      = out_valid_q;
  assign f_ir_o         = out_ir_q;
  assign f_pc_o         = out_pc_q;
  assign f_misaligned_o = out_mis_q;

endmodule
